// File: rtl/tdm_pkg.sv
// Shared types and constants for the tdm_demux14 time-division demultiplexer.
// Contents: FSM state enum, default frame geometry, error-counter width.
package tdm_pkg;

  typedef enum logic {
    HUNT,
    LOCKED
  } tdm_state_e;

  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefLaneW = 1;
  localparam int unsigned ERRCNT_W = 8;

endpackage

// File: rtl/tdm_demux14_if.sv
// Bus between a slot-sequenced serial sender and the tdm_demux14 receiver.
// master: drives din/din_valid/sync/flush, observes the reassembled frame and status.
// slave : the demux; consumes the serial side, drives dout/dout_valid/slot/locked/sync_err.
interface tdm_demux14_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 1
);
  localparam int unsigned SEL_W = $clog2(LANES);

  logic [LANE_W-1:0]       din;
  logic                    din_valid;
  logic                    sync;
  logic                    flush;
  logic [LANES*LANE_W-1:0] dout;
  logic                    dout_valid;
  logic [SEL_W-1:0]        slot;
  logic                    locked;
  logic                    sync_err;

  modport master (
    output din, din_valid, sync, flush,
    input  dout, dout_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sync, flush,
    output dout, dout_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux.
// clk/rst  : clock, async active-high reset (slot -> 0)
// clr_i    : synchronous clear to slot 0 (highest priority)
// load_i   : sync seen; the current sample is slot 0, so the next expected slot is 1
// en_i     : advance by one, wrapping LANES-1 -> 0 (LANES is a power of two)
// slot_o   : next expected slot; last_o: slot_o == LANES-1
module tdm_slot_ctr #(
  parameter int unsigned LANES = 4,
  localparam int unsigned SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [SEL_W-1:0] slot_o,
  output logic             last_o
);

  logic [SEL_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load_i) begin
      slot_d = SEL_W'(1);
    end else if (en_i) begin
      slot_d = slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign last_o = (slot_q == SEL_W'(LANES - 1));

endmodule

// File: rtl/tdm_demux14.sv
// Time-division demultiplexer: rebuilds LANES-slot frames from a serial lane
// stream aligned by a sync marker on slot 0.
// clk, rst : clock, async active-high reset (clears state, assembly and dout)
// bus      : tdm_demux14_if.slave (din/din_valid/sync/flush in; dout, dout_valid,
//            slot, locked, sync_err out)
// err_cnt_o: saturating misplaced-sync count, present only with DEMUX_ERRCNT_EN
module tdm_demux14
  import tdm_pkg::*;
#(
  parameter int unsigned LANES  = DefLanes,
  parameter int unsigned LANE_W = DefLaneW
) (
  input  logic                clk,
  input  logic                rst,
  tdm_demux14_if.slave        bus
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt_o
`endif
);

  localparam int unsigned SEL_W = $clog2(LANES);
  localparam int unsigned W     = LANES * LANE_W;

  tdm_state_e       state_q, state_d;
  logic [W-1:0]     asm_q, asm_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             locked_q;
  logic             ctr_clr, ctr_load, ctr_en, ctr_last;
  logic [SEL_W-1:0] slot;

  tdm_slot_ctr #(
    .LANES (LANES)
  ) u_slot_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ctr_clr),
    .load_i (ctr_load),
    .en_i   (ctr_en),
    .slot_o (slot),
    .last_o (ctr_last)
  );

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    ctr_clr      = 1'b0;
    ctr_load     = 1'b0;
    ctr_en       = 1'b0;
    if (bus.flush) begin
      // dout is deliberately kept; only the partial frame and alignment go.
      state_d = HUNT;
      asm_d   = '0;
      ctr_clr = 1'b1;
    end else if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            state_d             = LOCKED;
            asm_d               = '0;
            asm_d[LANE_W-1:0]   = bus.din;
            ctr_load            = 1'b1;
          end
        end
        LOCKED: begin
          if (bus.sync && (slot != '0)) begin
            // Misplaced sync: drop the partial frame, restart with this sample as slot 0.
            sync_err_d          = 1'b1;
            asm_d               = '0;
            asm_d[LANE_W-1:0]   = bus.din;
            ctr_load            = 1'b1;
          end else begin
            asm_d[32'(slot) * LANE_W +: LANE_W] = bus.din;
            ctr_en = 1'b1;
            if (ctr_last) begin
              dout_d       = asm_d;
              dout_valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= (state_q == LOCKED);
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;

`ifdef DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.flush) begin
      err_cnt_d = '0;
    end else if (sync_err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/tdm_demux14.md
Name: tdm_demux14

Overview:
- Time-division demultiplexer: receives a serial lane stream (one lane sample per valid cycle, slot order 0..LANES-1) and reassembles full frames into a parallel word.
- Acts as the receiving end of the 4:1 select-driven mux path. The mux drives slot i's data on its output while its select equals i; this block tracks the slot and rebuilds d[LANES-1:0].
- Sits between a slot-sequenced serial link and downstream parallel logic.
- Frame alignment comes from a sync marker on slot 0.

Parameters:
- LANES, 4, number of TDM slots per frame; power of two, at least 2.
- LANE_W, 1, bits carried per slot.
- SEL_W, $clog2(LANES), slot index width; derived, do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- din  input  LANE_W  serial lane sample.
- din_valid  input  1  din is valid this cycle.
- sync  input  1  marks the din sample as slot 0; qualified by din_valid.
- flush  input  1  synchronous return to HUNT.
- dout  output  LANES*LANE_W  reassembled frame; slot k occupies bits [k*LANE_W +: LANE_W].
- dout_valid  output  1  one-cycle pulse when dout is updated.
- slot  output  SEL_W  index of the next expected slot (the equivalent of the mux select).
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on a misplaced sync.

Behaviour:
- Reset (async, rst=1) forces:
  - state=HUNT, slot=0;
  - internal assembly register=0, dout=0;
  - dout_valid=0, locked=0, sync_err=0.
- FSM states are HUNT and LOCKED. locked is a registered copy of (state==LOCKED).
- Cycles with din_valid=0: all state holds, and dout_valid/sync_err are 0.
- HUNT:
  - din_valid && sync: lane 0 <- din, slot <- 1, go to LOCKED.
  - din_valid && !sync: sample discarded, slot stays 0.
- LOCKED, on din_valid:
  - sync && slot!=0:
    - sync_err=1 for the next cycle;
    - partial frame discarded, with no dout_valid;
    - sample taken as the new slot 0: lane 0 <- din, slot <- 1.
  - Otherwise: lane[slot] <- din, slot <- slot+1, wrapping from LANES-1 to 0.
  - sync && slot==0 is legal realignment. Missing sync at slot 0 is also legal (freewheel).
- Frame completion:
  - Trigger: the capture of slot LANES-1.
  - dout <- assembled word including that sample, registered.
  - dout_valid=1 in the cycle after that sample (latency 1 clk).
  - dout holds until the next completed frame.
- Back-to-back: with din_valid held high, dout_valid pulses every LANES cycles. There are no bubbles between frames.
- flush=1 (synchronous) has priority over din:
  - state=HUNT, slot=0, partial frame cleared;
  - dout is retained;
  - dout_valid and sync_err are 0 that cycle.
- Reset mid-frame discards the partial frame and clears dout immediately (async).
- The assembly register is independent of dout. A partial frame never alters dout.

Optional Feature:
- DEMUX_ERRCNT_EN defined:
  - adds output err_cnt [7:0], reset to 0;
  - increments on each sync_err pulse and saturates at 8'hFF;
  - cleared by flush.
- Undefined: no err_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Package tdm_pkg holds:
  - typedef enum logic {HUNT, LOCKED} tdm_state_e;
  - default LANES/LANE_W constants;
  - the ERRCNT_W=8 constant.
- One natural sub-module, tdm_slot_ctr: SEL_W-bit wrap counter with enable, sync-load and clear, providing slot and a last-slot flag.

Test Plan:
- Frame alignment: LANES=4, LANE_W=1, din_valid=1, sync on the first sample, din=0,1,0,0 -> one cycle after the 4th sample, dout=4'b0010 and dout_valid=1 for 1 cycle; locked=1 from cycle 2.
- Back-to-back frames: frames 0,1,0,0 then 0,0,1,0 with no gap -> dout=0010 then 0100, dout_valid pulses exactly 4 cycles apart.
- Pre-sync discard: din_valid low on alternate cycles, plus 3 samples before any sync -> the pre-sync samples are ignored, slot advances only on valid cycles, and dout is still correct.
- Misplaced sync: sync asserted at slot=2 -> sync_err pulse, no dout_valid, slot=1 next cycle, and the next full frame decodes correctly.
- Flush and reset mid-frame: flush after 2 samples -> locked=0, slot=0, dout unchanged. Async rst pulse mid-frame -> dout=0 immediately with no clock edge.
- DEMUX_ERRCNT_EN: 300 misplaced syncs -> err_cnt=8'hFF (saturated); flush -> err_cnt=0.
